// File: rtl/carry_lookahead_adder_pkg.sv
// Shared constants and sizing helper for the two-level carry-lookahead adder.
package carry_lookahead_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 3;
    localparam int unsigned DEFAULT_GROUP = 4;

    // Number of lookahead groups needed to cover a width, the last one possibly partial.
    function automatic int unsigned num_groups(input int unsigned width, input int unsigned group);
        return (width + group - 1) / group;
    endfunction

endpackage

// File: rtl/carry_lookahead_adder_if.sv
// Operand/result bundle for carry_lookahead_adder; o_ovf_q exists only under
// CARRY_LOOKAHEAD_ADDER_OVF_EN.
interface carry_lookahead_adder_if
    import carry_lookahead_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0] add1;
    logic [WIDTH-1:0] add2;
    logic [WIDTH:0]   result;
    logic [WIDTH:0]   result_q;
`ifdef CARRY_LOOKAHEAD_ADDER_OVF_EN
    logic             ovf_q;

    modport master (output add1, output add2, input result, input result_q, input ovf_q);
    modport slave  (input add1, input add2, output result, output result_q, output ovf_q);
`else
    modport master (output add1, output add2, input result, input result_q);
    modport slave  (input add1, input add2, output result, output result_q);
`endif
endinterface

// File: rtl/carry_lookahead_adder_group.sv
// One lookahead block of GROUP bits: flattened in-group carries, sum, and the
// group generate/propagate pair consumed by the second-level lookahead.
module cla_group #(
    parameter int unsigned GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] sum,
    output logic             gg,
    output logic             gp
);

    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] carry;

    assign g = a & b;
    assign p = a ^ b;

    // c[i] = OR_j ( g[j] & p[j+1..i-1] ) | ( p[0..i-1] & cin ), no ripple chain
    always_comb begin
        logic gen_acc;
        logic prop_acc;
        logic term;
        carry    = '0;
        gen_acc  = 1'b0;
        prop_acc = 1'b1;
        term     = 1'b0;
        carry[0] = cin;
        for (int i = 1; i < int'(GROUP); i++) begin
            gen_acc  = 1'b0;
            prop_acc = 1'b1;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int m = j + 1; m < i; m++) begin
                    term = term & p[m];
                end
                gen_acc  = gen_acc | term;
                prop_acc = prop_acc & p[j];
            end
            carry[i] = gen_acc | (prop_acc & cin);
        end
    end

    // Group generate: a carry is produced inside the group regardless of cin
    always_comb begin
        logic term;
        gg   = 1'b0;
        term = 1'b0;
        for (int j = 0; j < int'(GROUP); j++) begin
            term = g[j];
            for (int m = j + 1; m < int'(GROUP); m++) begin
                term = term & p[m];
            end
            gg = gg | term;
        end
    end

    assign gp  = &p;
    assign sum = p ^ carry;

endmodule

// File: rtl/carry_lookahead_adder.sv
// Two-level carry-lookahead adder with registered copy of the sum.
// Optional signed-overflow flag under CARRY_LOOKAHEAD_ADDER_OVF_EN.
module carry_lookahead_adder
    import carry_lookahead_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned GROUP = DEFAULT_GROUP
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_add1,
    input  logic [WIDTH-1:0] i_add2,
    output logic [WIDTH:0]   o_result,
    output logic [WIDTH:0]   o_result_q
`ifdef CARRY_LOOKAHEAD_ADDER_OVF_EN
    ,
    output logic             o_ovf_q
`endif
);

    localparam int unsigned NGROUPS = num_groups(WIDTH, GROUP);

    logic [NGROUPS-1:0] grp_g;
    logic [NGROUPS-1:0] grp_p;
    logic [NGROUPS:0]   grp_c;
    logic [WIDTH-1:0]   sum;

    // Last group is sized to the remaining bits so its generate is the true carry-out
    for (genvar k = 0; k < int'(NGROUPS); k++) begin : g_grp
        localparam int unsigned LO = 32'(k) * GROUP;
        localparam int unsigned GW = (LO + GROUP > WIDTH) ? (WIDTH - LO) : GROUP;

        cla_group #(
            .GROUP (GW)
        ) u_grp (
            .a   (i_add1[LO +: GW]),
            .b   (i_add2[LO +: GW]),
            .cin (grp_c[k]),
            .sum (sum[LO +: GW]),
            .gg  (grp_g[k]),
            .gp  (grp_p[k])
        );
    end

    // Second-level lookahead over group G/P; adder carry-in is tied to 0
    always_comb begin
        logic acc;
        logic term;
        grp_c    = '0;
        acc      = 1'b0;
        term     = 1'b0;
        grp_c[0] = 1'b0;
        for (int k = 0; k < int'(NGROUPS); k++) begin
            acc = 1'b0;
            for (int j = 0; j <= k; j++) begin
                term = grp_g[j];
                for (int m = j + 1; m <= k; m++) begin
                    term = term & grp_p[m];
                end
                acc = acc | term;
            end
            grp_c[k+1] = acc;
        end
    end

    assign o_result = {grp_c[NGROUPS], sum};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_result_q <= '0;
        end else begin
            o_result_q <= o_result;
        end
    end

`ifdef CARRY_LOOKAHEAD_ADDER_OVF_EN
    logic ovf_c;

    // Like-signed operands whose WIDTH-bit sum flips sign
    assign ovf_c = (i_add1[WIDTH-1] == i_add2[WIDTH-1]) && (sum[WIDTH-1] != i_add1[WIDTH-1]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ovf_q <= 1'b0;
        end else begin
            o_ovf_q <= ovf_c;
        end
    end
`endif

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// Directed self-checking bench for carry_lookahead_adder at several WIDTH/GROUP
// points; overflow checks compile in with CARRY_LOOKAHEAD_ADDER_OVF_EN.
module tb_carry_lookahead_adder;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_pass;

    carry_lookahead_adder_if #(.WIDTH(3))  if3 ();
    carry_lookahead_adder_if #(.WIDTH(8))  if8 ();
    carry_lookahead_adder_if #(.WIDTH(5))  if5 ();
    carry_lookahead_adder_if #(.WIDTH(16)) if16 ();

    carry_lookahead_adder #(.WIDTH(3), .GROUP(4)) u_dut3 (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_add1     (if3.add1),
        .i_add2     (if3.add2),
        .o_result   (if3.result),
        .o_result_q (if3.result_q)
`ifdef CARRY_LOOKAHEAD_ADDER_OVF_EN
        ,
        .o_ovf_q    (if3.ovf_q)
`endif
    );

    carry_lookahead_adder #(.WIDTH(8), .GROUP(4)) u_dut8 (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_add1     (if8.add1),
        .i_add2     (if8.add2),
        .o_result   (if8.result),
        .o_result_q (if8.result_q)
`ifdef CARRY_LOOKAHEAD_ADDER_OVF_EN
        ,
        .o_ovf_q    (if8.ovf_q)
`endif
    );

    carry_lookahead_adder #(.WIDTH(5), .GROUP(4)) u_dut5 (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_add1     (if5.add1),
        .i_add2     (if5.add2),
        .o_result   (if5.result),
        .o_result_q (if5.result_q)
`ifdef CARRY_LOOKAHEAD_ADDER_OVF_EN
        ,
        .o_ovf_q    (if5.ovf_q)
`endif
    );

    carry_lookahead_adder #(.WIDTH(16), .GROUP(3)) u_dut16 (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_add1     (if16.add1),
        .i_add2     (if16.add2),
        .o_result   (if16.result),
        .o_result_q (if16.result_q)
`ifdef CARRY_LOOKAHEAD_ADDER_OVF_EN
        ,
        .o_ovf_q    (if16.ovf_q)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Directed vectors for the wider instances: {a, b, expected sum}
    typedef struct {
        int unsigned a;
        int unsigned b;
        int unsigned s;
    } vec_t;

    vec_t v8  [6] = '{'{255, 1, 256}, '{128, 128, 256}, '{100, 27, 127},
                      '{0, 0, 0}, '{170, 85, 255}, '{15, 1, 16}};
    vec_t v5  [4] = '{'{31, 31, 62}, '{16, 15, 31}, '{15, 1, 16}, '{3, 5, 8}};
    vec_t v16 [5] = '{'{65535, 1, 65536}, '{4095, 1, 4096}, '{40000, 30000, 70000},
                      '{12345, 54321, 66666}, '{32767, 32767, 65534}};

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b1;
        if3.add1  = '0;
        if3.add2  = '0;
        if8.add1  = '0;
        if8.add2  = '0;
        if5.add1  = '0;
        if5.add2  = '0;
        if16.add1 = '0;
        if16.add2 = '0;

        #1 rst_n = 1'b0;
        if3.add1 = 3'd5;
        if3.add2 = 3'd3;
        #1;
        check("rst_q3",  64'(if3.result_q), 64'd0);
        check("rst_q8",  64'(if8.result_q), 64'd0);
        check("rst_q16", 64'(if16.result_q), 64'd0);
        check("rst_comb_5p3", 64'(if3.result), 64'd8);
`ifdef CARRY_LOOKAHEAD_ADDER_OVF_EN
        check("rst_ovf", 64'(if3.ovf_q), 64'd0);
`endif
        @(posedge clk);
        #1 check("rst_hold_q3", 64'(if3.result_q), 64'd0);

        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive 3-bit operand space, ten passes
        for (int pass = 0; pass < 10; pass++) begin
            for (int a = 0; a < 8; a++) begin
                for (int b = 0; b < 8; b++) begin
                    if3.add1 = 3'(a);
                    if3.add2 = 3'(b);
                    #1 check("exh3", 64'(if3.result), 64'(a + b));
                end
            end
        end

        // Registered path: one-edge latency, no enable
        @(negedge clk);
        if3.add1 = 3'd6;
        if3.add2 = 3'd1;
        @(posedge clk);
        #1 check("lat_6p1", 64'(if3.result_q), 64'd7);
        if3.add1 = 3'd2;
        if3.add2 = 3'd2;
        @(posedge clk);
        #1 check("lat_2p2", 64'(if3.result_q), 64'd4);

        // Asynchronous reset between edges, then first capture after release
        @(negedge clk);
        if3.add1 = 3'd7;
        if3.add2 = 3'd7;
        @(posedge clk);
        #1 check("pre_rst_q", 64'(if3.result_q), 64'd14);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_q", 64'(if3.result_q), 64'd0);
        check("rst_comb_14", 64'(if3.result), 64'd14);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rel_no_edge_q", 64'(if3.result_q), 64'd0);
        @(posedge clk);
        #1 check("rel_first_cap", 64'(if3.result_q), 64'd14);

        for (int i = 0; i < 6; i++) begin
            if8.add1 = 8'(v8[i].a);
            if8.add2 = 8'(v8[i].b);
            #1 check("w8g4", 64'(if8.result), 64'(v8[i].s));
        end
        for (int i = 0; i < 4; i++) begin
            if5.add1 = 5'(v5[i].a);
            if5.add2 = 5'(v5[i].b);
            #1 check("w5g4", 64'(if5.result), 64'(v5[i].s));
        end
        for (int i = 0; i < 5; i++) begin
            if16.add1 = 16'(v16[i].a);
            if16.add2 = 16'(v16[i].b);
            #1 check("w16g3", 64'(if16.result), 64'(v16[i].s));
        end

        @(negedge clk);
        if8.add1 = 8'd255;
        if8.add2 = 8'd1;
        @(posedge clk);
        #1 check("w8_q_255p1", 64'(if8.result_q), 64'd256);

`ifdef CARRY_LOOKAHEAD_ADDER_OVF_EN
        @(negedge clk);
        if3.add1 = 3'd3;
        if3.add2 = 3'd1;
        @(posedge clk);
        #1 check("ovf_3p1", 64'(if3.ovf_q), 64'd1);
        if3.add1 = 3'd3;
        if3.add2 = 3'd4;
        @(posedge clk);
        #1 check("ovf_3p4", 64'(if3.ovf_q), 64'd0);
        if3.add1 = 3'd4;
        if3.add2 = 3'd4;
        @(posedge clk);
        #1 check("ovf_4p4", 64'(if3.ovf_q), 64'd1);
        if3.add1 = 3'd1;
        if3.add2 = 3'd2;
        @(posedge clk);
        #1 check("ovf_1p2", 64'(if3.ovf_q), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
